// File: rtl/ad7266_adc_emu_pkg.sv
// ---------------------------------------------------------------------------
// ad7266_adc_emu_pkg
//  Shared constants and FSM state type for the AD7266 serial-side emulator.
//  FRAME_BITS_DEF : SCLK falling edges in one complete frame
//  LEAD_ZEROS     : zero bits shifted out ahead of the ADC code
//  DATA_W_DEF     : ADC code width
//  emu_state_t    : IDLE / SHIFT / DONE frame states
// ---------------------------------------------------------------------------
package ad7266_adc_emu_pkg;

   localparam int FRAME_BITS_DEF = 16;
   localparam int LEAD_ZEROS     = 2;
   localparam int DATA_W_DEF     = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } emu_state_t;

endpackage

// File: rtl/ad7266_adc_emu_sync.sv
// ---------------------------------------------------------------------------
// ad7266_adc_emu_sync
//  Multi-flop synchronizer for one asynchronous input plus an edge-detect
//  flop. Edge pulses appear STAGES+1 clk edges after the input changes
//  (counting the consumer's register stage).
//  Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   din   in  asynchronous input
//   rise  out 1-clk pulse on a synchronized 0->1 transition
//   fall  out 1-clk pulse on a synchronized 1->0 transition
//  RST_VAL is the assumed idle level of din, so a line sitting at its idle
//  level when reset is released does not produce a spurious edge.
// ---------------------------------------------------------------------------
module ad7266_adc_emu_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_reg;
   logic              prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= {STAGES{RST_VAL}};
         prev_reg <= RST_VAL;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], din};
         prev_reg <= sync_reg[STAGES-1];
      end
   end

   assign rise =  sync_reg[STAGES-1] & ~prev_reg;
   assign fall = ~sync_reg[STAGES-1] &  prev_reg;

endmodule

// File: rtl/ad7266_adc_emu.sv
// ---------------------------------------------------------------------------
// ad7266_adc_emu
//  Synthesizable stand-in for the serial side of an AD7266 dual ADC. SCLK and
//  CS_N are oversampled on clk; on a CS_N fall the channel/config inputs are
//  latched and one frame per port is shifted out on SCLK falls:
//  2 leading zeros, DATA_W-bit code MSB first, trailing zeros.
//  Optional feature macro: AD7266_EMU_RAMP_EN
//   defined   : codes come from internal up (A) / down (B) ramps that step on
//               every completed frame; PAT_A / PAT_B are ignored.
//   undefined : codes are PAT_A / PAT_B as seen at the CS_N fall.
//  Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   SCLK, CS_N           serial clock / chip select from the controller
//   RANGE, SGL_DIFN      config bits, latched at CS_N fall
//   A0, A1, A2           channel address, latched at CS_N fall
//   PAT_A, PAT_B         static codes for ports A / B
//   DOUTA, DOUTB         serial data out (driven 0 whenever not shifting)
//   CFG_ADDR, CFG_RANGE,
//   CFG_SGL              config captured for the last frame
//   FRAME_CNT            completed-frame counter (wraps)
//   FRAME_ERR            1-clk pulse when CS_N rises before a frame completes
// ---------------------------------------------------------------------------
module ad7266_adc_emu
   import ad7266_adc_emu_pkg::*;
#(
   parameter int              SYNC_STAGES = 2,
   parameter int              DATA_W      = DATA_W_DEF,
   parameter int              FRAME_BITS  = FRAME_BITS_DEF,
   parameter logic [DATA_W-1:0] PAT_A_RST = 12'h5A5,
   parameter logic [DATA_W-1:0] PAT_B_RST = 12'hA5A
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SCLK,
   input  logic              CS_N,
   input  logic              RANGE,
   input  logic              SGL_DIFN,
   input  logic              A0,
   input  logic              A1,
   input  logic              A2,
   input  logic [DATA_W-1:0] PAT_A,
   input  logic [DATA_W-1:0] PAT_B,
   output logic              DOUTA,
   output logic              DOUTB,
   output logic [2:0]        CFG_ADDR,
   output logic              CFG_RANGE,
   output logic              CFG_SGL,
   output logic [15:0]       FRAME_CNT,
   output logic              FRAME_ERR
);

   localparam int CNT_W       = $clog2(FRAME_BITS + 1);
   localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_W;

   // ---------------------------------------------------------------------
   // Input synchronizers
   // ---------------------------------------------------------------------
   logic sclk_fall;
   logic sclk_rise_unused;
   logic cs_fall;
   logic cs_rise;

   ad7266_adc_emu_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_sync_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (SCLK),
      .rise  (sclk_rise_unused),
      .fall  (sclk_fall)
   );

   ad7266_adc_emu_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_sync_cs (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (CS_N),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   emu_state_t            state_reg,     state_next;
   logic [FRAME_BITS-1:0] sh_a_reg,      sh_a_next;
   logic [FRAME_BITS-1:0] sh_b_reg,      sh_b_next;
   logic [CNT_W-1:0]      bit_cnt_reg,   bit_cnt_next;
   logic                  dout_a_reg,    dout_a_next;
   logic                  dout_b_reg,    dout_b_next;
   logic [2:0]            cfg_addr_reg,  cfg_addr_next;
   logic                  cfg_range_reg, cfg_range_next;
   logic                  cfg_sgl_reg,   cfg_sgl_next;
   logic [15:0]           frame_cnt_reg, frame_cnt_next;
   logic                  frame_err_reg, frame_err_next;
   logic                  frame_done;

   logic [DATA_W-1:0]     code_a;
   logic [DATA_W-1:0]     code_b;
   logic [FRAME_BITS-1:0] load_a;
   logic [FRAME_BITS-1:0] load_b;

   // ---------------------------------------------------------------------
   // Code source
   // ---------------------------------------------------------------------
`ifdef AD7266_EMU_RAMP_EN
   logic [DATA_W-1:0] ramp_a_reg;
   logic [DATA_W-1:0] ramp_b_reg;
   logic              unused_pat;

   // Ramps step once per completed frame; aborted frames leave them alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ramp_a_reg <= PAT_A_RST;
         ramp_b_reg <= PAT_B_RST;
      end else if (frame_done) begin
         ramp_a_reg <= ramp_a_reg + DATA_W'(1);
         ramp_b_reg <= ramp_b_reg - DATA_W'(1);
      end
   end

   assign code_a     = ramp_a_reg;
   assign code_b     = ramp_b_reg;
   assign unused_pat = ^{PAT_A, PAT_B};
`else
   // The pattern inputs are only consumed in the cycle the CS_N fall is
   // seen, so mid-frame changes never reach the shift registers.
   assign code_a = PAT_A;
   assign code_b = PAT_B;
`endif

   assign load_a = {{LEAD_ZEROS{1'b0}}, code_a, {TRAIL_ZEROS{1'b0}}};
   assign load_b = {{LEAD_ZEROS{1'b0}}, code_b, {TRAIL_ZEROS{1'b0}}};

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         sh_a_reg      <= '0;
         sh_b_reg      <= '0;
         bit_cnt_reg   <= '0;
         dout_a_reg    <= 1'b0;
         dout_b_reg    <= 1'b0;
         cfg_addr_reg  <= 3'd0;
         cfg_range_reg <= 1'b0;
         cfg_sgl_reg   <= 1'b0;
         frame_cnt_reg <= 16'd0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sh_a_reg      <= sh_a_next;
         sh_b_reg      <= sh_b_next;
         bit_cnt_reg   <= bit_cnt_next;
         dout_a_reg    <= dout_a_next;
         dout_b_reg    <= dout_b_next;
         cfg_addr_reg  <= cfg_addr_next;
         cfg_range_reg <= cfg_range_next;
         cfg_sgl_reg   <= cfg_sgl_next;
         frame_cnt_reg <= frame_cnt_next;
         frame_err_reg <= frame_err_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      sh_a_next      = sh_a_reg;
      sh_b_next      = sh_b_reg;
      bit_cnt_next   = bit_cnt_reg;
      dout_a_next    = dout_a_reg;
      dout_b_next    = dout_b_reg;
      cfg_addr_next  = cfg_addr_reg;
      cfg_range_next = cfg_range_reg;
      cfg_sgl_next   = cfg_sgl_reg;
      frame_cnt_next = frame_cnt_reg;
      frame_err_next = 1'b0;
      frame_done     = 1'b0;

      case (state_reg)
         IDLE: begin
            dout_a_next = 1'b0;
            dout_b_next = 1'b0;
            // Only CS_N is looked at here, so an SCLK fall seen in the same
            // cycle as the CS_N fall is discarded.
            if (cs_fall) begin
               state_next     = SHIFT;
               cfg_addr_next  = {A2, A1, A0};
               cfg_range_next = RANGE;
               cfg_sgl_next   = SGL_DIFN;
               sh_a_next      = load_a;
               sh_b_next      = load_b;
               dout_a_next    = load_a[FRAME_BITS-1];
               dout_b_next    = load_b[FRAME_BITS-1];
               bit_cnt_next   = '0;
            end
         end

         SHIFT: begin
            if (cs_rise) begin
               state_next     = IDLE;
               frame_err_next = 1'b1;
               dout_a_next    = 1'b0;
               dout_b_next    = 1'b0;
               bit_cnt_next   = '0;
            end else if (sclk_fall) begin
               sh_a_next    = {sh_a_reg[FRAME_BITS-2:0], 1'b0};
               sh_b_next    = {sh_b_reg[FRAME_BITS-2:0], 1'b0};
               dout_a_next  = sh_a_next[FRAME_BITS-1];
               dout_b_next  = sh_b_next[FRAME_BITS-1];
               bit_cnt_next = bit_cnt_reg + CNT_W'(1);
               if (bit_cnt_reg == CNT_W'(FRAME_BITS - 1)) begin
                  state_next     = DONE;
                  frame_cnt_next = frame_cnt_reg + 16'd1;
                  frame_done     = 1'b1;
                  dout_a_next    = 1'b0;
                  dout_b_next    = 1'b0;
               end
            end
         end

         DONE: begin
            // Extra SCLK edges after a complete frame read back as zeros.
            dout_a_next = 1'b0;
            dout_b_next = 1'b0;
            if (cs_rise) begin
               state_next   = IDLE;
               bit_cnt_next = '0;
            end
         end

         default: begin
            state_next  = IDLE;
            dout_a_next = 1'b0;
            dout_b_next = 1'b0;
         end
      endcase
   end

   assign DOUTA     = dout_a_reg;
   assign DOUTB     = dout_b_reg;
   assign CFG_ADDR  = cfg_addr_reg;
   assign CFG_RANGE = cfg_range_reg;
   assign CFG_SGL   = cfg_sgl_reg;
   assign FRAME_CNT = frame_cnt_reg;
   assign FRAME_ERR = frame_err_reg;

endmodule

// File: tb/tb_ad7266_adc_emu.sv
// ---------------------------------------------------------------------------
// tb_ad7266_adc_emu
//  Directed bench for ad7266_adc_emu. A simple controller model drives SCLK
//  at clk/8 (idle high) and samples DOUTA/DOUTB just before each SCLK fall.
//  Full frames come from a vector table; aborts, over-long frames, reset
//  mid-frame and mid-frame input changes are hand-written sequences.
//  Builds with or without AD7266_EMU_RAMP_EN.
// ---------------------------------------------------------------------------
module tb_ad7266_adc_emu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        SCLK = 1'b1;
   logic        CS_N = 1'b1;
   logic        RANGE = 1'b0;
   logic        SGL_DIFN = 1'b0;
   logic        A0 = 1'b0;
   logic        A1 = 1'b0;
   logic        A2 = 1'b0;
   logic [11:0] PAT_A = 12'h5A5;
   logic [11:0] PAT_B = 12'hA5A;
   logic        DOUTA;
   logic        DOUTB;
   logic [2:0]  CFG_ADDR;
   logic        CFG_RANGE;
   logic        CFG_SGL;
   logic [15:0] FRAME_CNT;
   logic        FRAME_ERR;

   ad7266_adc_emu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SCLK      (SCLK),
      .CS_N      (CS_N),
      .RANGE     (RANGE),
      .SGL_DIFN  (SGL_DIFN),
      .A0        (A0),
      .A1        (A1),
      .A2        (A2),
      .PAT_A     (PAT_A),
      .PAT_B     (PAT_B),
      .DOUTA     (DOUTA),
      .DOUTB     (DOUTB),
      .CFG_ADDR  (CFG_ADDR),
      .CFG_RANGE (CFG_RANGE),
      .CFG_SGL   (CFG_SGL),
      .FRAME_CNT (FRAME_CNT),
      .FRAME_ERR (FRAME_ERR)
   );

   always #5 clk = ~clk;

   int n_vec   = 0;
   int n_err   = 0;
   int err_cyc = 0;
   int exp_err = 0;
   int exp_cnt = 0;

   // Counts clk cycles with FRAME_ERR high; a correct pulse adds exactly 1.
   always @(negedge clk) if (FRAME_ERR === 1'b1) err_cyc++;

   typedef struct {
      logic [11:0] pa;
      logic [11:0] pb;
      logic [2:0]  addr;
      logic        rng;
      logic        sgl;
      logic [15:0] ea;
      logic [15:0] eb;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %-12s got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %-12s 0x%0h", name, act);
      end
   endtask

   task automatic set_cfg(input logic [2:0] addr, input logic rng, input logic sgl,
                          input logic [11:0] pa, input logic [11:0] pb);
      {A2, A1, A0} = addr;
      RANGE    = rng;
      SGL_DIFN = sgl;
      PAT_A    = pa;
      PAT_B    = pb;
   endtask

   // Lower CS_N, then issue n_falls SCLK cycles, sampling before each fall.
   // After mut_at falls the pattern/config inputs are inverted.
   task automatic run_frame(input int n_falls, input int mut_at,
                            output logic [31:0] cap_a, output logic [31:0] cap_b);
      cap_a = '0;
      cap_b = '0;
      @(negedge clk);
      CS_N = 1'b0;
      for (int i = 0; i < n_falls; i++) begin
         repeat (4) @(negedge clk);
         cap_a = {cap_a[30:0], DOUTA};
         cap_b = {cap_b[30:0], DOUTB};
         SCLK = 1'b0;
         repeat (4) @(negedge clk);
         SCLK = 1'b1;
         if (i + 1 == mut_at) begin
            PAT_A = ~PAT_A;
            PAT_B = ~PAT_B;
            A0    = ~A0;
            RANGE = ~RANGE;
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic end_frame();
      CS_N = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      CS_N  = 1'b1;
      SCLK  = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      exp_cnt = 0;
   endtask

   logic [31:0] ca;
   logic [31:0] cb;

   initial begin
      vecs[0] = '{12'h5A5, 12'hA5A, 3'd5, 1'b0, 1'b0, 16'h1694, 16'h2968};
      vecs[1] = '{12'hFFF, 12'h000, 3'd7, 1'b1, 1'b1, 16'h3FFC, 16'h0000};
      vecs[2] = '{12'h000, 12'hFFF, 3'd0, 1'b0, 1'b1, 16'h0000, 16'h3FFC};
      vecs[3] = '{12'h001, 12'h800, 3'd2, 1'b1, 1'b0, 16'h0004, 16'h2000};
      vecs[4] = '{12'h123, 12'hABC, 3'd4, 1'b0, 1'b1, 16'h048C, 16'h2AF0};
      vecs[5] = '{12'h800, 12'h001, 3'd3, 1'b1, 1'b1, 16'h2000, 16'h0004};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_dout", {30'd0, DOUTA, DOUTB}, 32'd0);
      check("rst_cfg", {27'd0, CFG_ADDR, CFG_RANGE, CFG_SGL}, 32'd0);
      check("rst_cnt", {16'd0, FRAME_CNT}, 32'd0);
      check("rst_err", {31'd0, FRAME_ERR}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

`ifdef AD7266_EMU_RAMP_EN
      // Ramp codes over three frames from reset
      begin
         logic [15:0] ra [3];
         logic [15:0] rb [3];
         ra = '{16'h1694, 16'h1698, 16'h169C};
         rb = '{16'h2968, 16'h2964, 16'h2960};
         set_cfg(3'd5, 1'b0, 1'b0, 12'h000, 12'h000);
         for (int k = 0; k < 3; k++) begin
            run_frame(16, -1, ca, cb);
            end_frame();
            exp_cnt++;
            check("ramp_a", ca, {16'd0, ra[k]});
            check("ramp_b", cb, {16'd0, rb[k]});
            check("ramp_cnt", {16'd0, FRAME_CNT}, exp_cnt);
         end
         do_reset();
      end
`else
      // Table of complete static-pattern frames
      for (int k = 0; k < 6; k++) begin
         set_cfg(vecs[k].addr, vecs[k].rng, vecs[k].sgl, vecs[k].pa, vecs[k].pb);
         run_frame(16, -1, ca, cb);
         check("done_dout", {30'd0, DOUTA, DOUTB}, 32'd0);
         end_frame();
         exp_cnt++;
         check("data_a", ca, {16'd0, vecs[k].ea});
         check("data_b", cb, {16'd0, vecs[k].eb});
         check("cfg", {27'd0, CFG_ADDR, CFG_RANGE, CFG_SGL},
               {27'd0, vecs[k].addr, vecs[k].rng, vecs[k].sgl});
         check("frame_cnt", {16'd0, FRAME_CNT}, exp_cnt);
         check("err_cyc", err_cyc, exp_err);
      end
`endif

      // Abort after 9 SCLK falls
      set_cfg(3'd5, 1'b0, 1'b0, 12'h5A5, 12'hA5A);
      run_frame(9, -1, ca, cb);
      end_frame();
      exp_err++;
      check("abort_bits_a", ca, 32'h02D);
      check("abort_err", err_cyc, exp_err);
      check("abort_cnt", {16'd0, FRAME_CNT}, exp_cnt);
      check("abort_dout", {30'd0, DOUTA, DOUTB}, 32'd0);

      // 20 SCLK falls in one frame: bits 17..20 read 0
      run_frame(20, -1, ca, cb);
      end_frame();
      exp_cnt++;
      check("long_a", ca, 32'h16940);
      check("long_b", cb, 32'h29680);
      check("long_cnt", {16'd0, FRAME_CNT}, exp_cnt);
      check("long_err", err_cyc, exp_err);

      // Reset after 6 SCLK falls, then a fresh frame
      set_cfg(3'd6, 1'b1, 1'b1, 12'h5A5, 12'hA5A);
      run_frame(6, -1, ca, cb);
      @(negedge clk);
      rst_n = 1'b0;
      CS_N  = 1'b1;
      #1;
      check("mrst_cnt", {16'd0, FRAME_CNT}, 32'd0);
      check("mrst_cfg", {27'd0, CFG_ADDR, CFG_RANGE, CFG_SGL}, 32'd0);
      check("mrst_dout", {30'd0, DOUTA, DOUTB}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      repeat (2) @(negedge clk);
      set_cfg(3'd5, 1'b0, 1'b0, 12'h5A5, 12'hA5A);
      run_frame(16, -1, ca, cb);
      end_frame();
      exp_cnt++;
      check("post_rst_a", ca, 32'h1694);
      check("post_rst_b", cb, 32'h2968);
      check("post_rst_cnt", {16'd0, FRAME_CNT}, exp_cnt);

      // Pattern / address / range changed after 5 falls are ignored
      set_cfg(3'd1, 1'b0, 1'b1, 12'h123, 12'hABC);
      run_frame(16, 5, ca, cb);
      end_frame();
      exp_cnt++;
`ifdef AD7266_EMU_RAMP_EN
      check("mid_a", ca, 32'h1698);
      check("mid_b", cb, 32'h2964);
`else
      check("mid_a", ca, 32'h048C);
      check("mid_b", cb, 32'h2AF0);
`endif
      check("mid_cfg", {27'd0, CFG_ADDR, CFG_RANGE, CFG_SGL}, {27'd0, 3'd1, 1'b0, 1'b1});
      check("mid_cnt", {16'd0, FRAME_CNT}, exp_cnt);
      check("final_err", err_cyc, exp_err);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
